popcount_stream: RTL and testbench
==================================

# popcount_stream

Streaming population counter that sits directly downstream of a 7:3 compressor stage. Each accepted 7-bit chunk is reduced to a 3-bit ones-count (0..7) and accumulated into a per-frame total. The frame total is emitted when the chunk tagged `last` retires. Input and output both use valid/ready handshakes, the block sustains one chunk per cycle, and the total saturates at the counter width with a sticky flag.

## Interface

- `CNT_W`, default 8: width of the frame total; must be ≥ 3.

- `clk` in 1: single clock; all state updates on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `in_data` in 7: chunk whose set bits are counted.
- `in_valid` in 1: chunk present.
- `in_last` in 1: chunk is the final one of its frame.
- `in_ready` out 1: block accepts chunk this cycle.
- `out_count` out CNT_W: frame ones-count, clamped at 2^CNT_W−1.
- `out_sat` out 1: frame total exceeded 2^CNT_W−1.
- `out_valid` out 1: result present.
- `out_ready` in 1: consumer takes result this cycle.

## Operation

- Pipeline stages:
  - **S1 (compress):** on input handshake (`in_valid && in_ready`), register `s1_cnt` = popcount(`in_data`) (3 bits) and `s1_last`, and set `s1_valid`.
  - **S2 (accumulate):** holds `acc` (CNT_W bits) and the sticky `acc_sat`.
  - **Output register:** holds `out_count`, `out_sat` and `out_valid`.
- S1 retirement (`s1_adv`): `s1_valid && !(s1_last && out_valid && !out_ready)`.
  - A non-last chunk always retires.
  - A last chunk stalls only while the output register is full and not being taken.
- `in_ready = !s1_valid || s1_adv`, combinational. There is no combinational path from `in_valid` to `in_ready`.
- Arithmetic on retirement:
  - Compute `sum = acc + s1_cnt` at CNT_W+1 bits.
  - If `sum > 2^CNT_W−1`, then `nxt = 2^CNT_W−1` and `nxt_sat = 1`.
  - Otherwise `nxt = sum[CNT_W−1:0]` and `nxt_sat = acc_sat`.
- Non-last retirement: `acc ← nxt`, `acc_sat ← nxt_sat`.
- Last retirement:
  - `out_count ← nxt`, `out_sat ← nxt_sat`, `out_valid ← 1`.
  - Clear `acc` and `acc_sat` to 0, so the next frame starts clean.
- Output register states:
  - **EMPTY → FULL:** on last retirement.
  - **FULL → EMPTY:** on `out_ready` with no simultaneous last retirement.
  - **FULL → FULL:** on `out_ready` with a simultaneous last retirement. The new result replaces the old one and `out_valid` stays 1.
- While `out_valid` is 1, `out_count` and `out_sat` are stable until the handshake.
- A single-chunk frame (`in_last` on the first chunk) is legal.
- A zero-count frame produces `out_count = 0`.
- There is no frame-length limit. Saturation covers overflow.

## Timing

- Reset values: `out_valid` = 0, `out_count` = 0, `out_sat` = 0, `s1_valid` = 0, `acc` = 0, `acc_sat` = 0.
  - `in_ready` reads 1 from the first cycle after reset.
- Reset during a frame discards the partial accumulation and any pending result. The next accepted chunk starts a new frame.
- Latency: last chunk accepted at edge N → `out_valid` = 1 after edge N+1. The result is visible in cycle N+1, i.e. 2 registers from input to output.
- Throughput: 1 chunk per cycle with `out_ready` held high, including back-to-back single-chunk frames (1 result per cycle).
- Backpressure:
  - With the output full and `out_ready` = 0, at most one further last chunk waits in S1. `in_ready` is then 0.
  - Non-last chunks continue to flow until a last chunk reaches S1.
- `in_data` and `in_last` are ignored when `in_valid` = 0.
- `out_ready` is ignored when `out_valid` = 0.

## Test plan

- **Reset:** hold `rst` 2 cycles with random inputs → `out_valid` = 0, `out_count` = 0, `out_sat` = 0; `in_ready` = 1 on the first cycle after release.
- **Basic frame:** CNT_W = 8, chunks 7'h7F, 7'h01, 7'h55 (last) on consecutive cycles, `out_ready` = 1 → single result `out_count` = 12, `out_sat` = 0, valid exactly one cycle after the last-chunk acceptance edge.
- **Saturation:** CNT_W = 4, chunks 7'h7F ×3 (third last) → `out_count` = 15, `out_sat` = 1; next frame 7'h03 (last) → `out_count` = 2, `out_sat` = 0.
- **Backpressure:** `out_ready` = 0, send frames {7'h07 last}, {7'h1F last}, {7'h01 last} back to back:
  - `in_ready` drops after the second frame is accepted.
  - The first result (3) is held stable.
  - Raise `out_ready` → results 3, 5, 1 appear in order, none lost or duplicated.
- **Reset mid-frame:** chunks 7'h7F, 7'h7F (not last), assert `rst` 1 cycle, then 7'h03 (last) → `out_count` = 2.
- **Back-to-back singles:** 8 consecutive single-chunk frames with popcounts 0..7 and `out_ready` = 1 → `out_valid` high 8 consecutive cycles, values 0..7 in order; random `out_ready` toggling yields the same sequence.

Source files
------------

// File: rtl/popcount_stream.sv
// Streaming 7-bit chunk popcount with per-frame saturating total.
// Two registers deep: S1 chunk count, then accumulate into the output register.
module popcount_stream #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       in_data,
    input  logic             in_valid,
    input  logic             in_last,
    output logic             in_ready,
    output logic [CNT_W-1:0] out_count,
    output logic             out_sat,
    output logic             out_valid,
    input  logic             out_ready
);

    localparam logic EMPTY = 1'b0;
    localparam logic FULL  = 1'b1;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    function automatic logic [2:0] popcount7(input logic [6:0] d);
        logic [2:0] c;
        c = 3'd0;
        for (int i = 0; i < 7; i++) begin
            c = c + {2'b00, d[i]};
        end
        return c;
    endfunction

    logic             s1_valid;
    logic             s1_last;
    logic [2:0]       s1_cnt;
    logic [CNT_W-1:0] acc;
    logic             acc_sat;
    logic             out_state;

    logic             s1_adv;
    logic             in_fire;
    logic             out_fire;
    logic [CNT_W:0]   sum;
    logic [CNT_W-1:0] nxt;
    logic             nxt_sat;

    assign out_valid = (out_state == FULL);
    assign out_fire  = out_valid && out_ready;

    // Only a last chunk needs the output slot, so only it can stall S1
    assign s1_adv   = s1_valid && !(s1_last && out_valid && !out_ready);
    assign in_ready = !s1_valid || s1_adv;
    assign in_fire  = in_valid && in_ready;

    assign sum = {1'b0, acc} + {{(CNT_W-2){1'b0}}, s1_cnt};

    always_comb begin
        nxt     = sum[CNT_W-1:0];
        nxt_sat = acc_sat;
        if (sum[CNT_W]) begin
            nxt     = CNT_MAX;
            nxt_sat = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_last  <= 1'b0;
            s1_cnt   <= 3'd0;
        end else if (in_fire) begin
            s1_valid <= 1'b1;
            s1_last  <= in_last;
            s1_cnt   <= popcount7(in_data);
        end else if (s1_adv) begin
            s1_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc     <= '0;
            acc_sat <= 1'b0;
        end else if (s1_adv) begin
            if (s1_last) begin
                acc     <= '0;
                acc_sat <= 1'b0;
            end else begin
                acc     <= nxt;
                acc_sat <= nxt_sat;
            end
        end
    end

    // A last retirement during a take replaces the result and stays FULL
    always_ff @(posedge clk) begin
        if (rst) begin
            out_state <= EMPTY;
            out_count <= '0;
            out_sat   <= 1'b0;
        end else if (s1_adv && s1_last) begin
            out_state <= FULL;
            out_count <= nxt;
            out_sat   <= nxt_sat;
        end else if (out_fire) begin
            out_state <= EMPTY;
        end
    end

endmodule

// File: tb/tb_popcount_stream.sv
// Bench for popcount_stream: CNT_W=8 and CNT_W=4 instances share stimulus.
// Expected results come from per-frame integer totals clamped per width.
module tb_popcount_stream;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [6:0] in_data = '0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       out_ready = 1'b0;

    logic       in_ready8, out_sat8, out_valid8;
    logic [7:0] out_count8;
    logic       in_ready4, out_sat4, out_valid4;
    logic [3:0] out_count4;

    always #5 clk = ~clk;

    popcount_stream #(.CNT_W(8)) dut8 (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready8),
        .out_count(out_count8), .out_sat(out_sat8),
        .out_valid(out_valid8), .out_ready(out_ready)
    );

    popcount_stream #(.CNT_W(4)) dut4 (
        .clk(clk), .rst(rst),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last),
        .in_ready(in_ready4),
        .out_count(out_count4), .out_sat(out_sat4),
        .out_valid(out_valid4), .out_ready(out_ready)
    );

    typedef struct {
        int   c8;
        logic s8;
        int   c4;
        logic s4;
    } res_t;

    res_t q[$];
    int   fsum = 0;
    int   total = 0;
    int   bad = 0;
    int   vcount = 0;
    int   cyc = 0;
    logic accepted = 1'b0;
    logic rand_ready = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic res_t frame_result(input int s);
        res_t r;
        r.c8 = (s > 255) ? 255 : s;
        r.s8 = (s > 255);
        r.c4 = (s > 15) ? 15 : s;
        r.s4 = (s > 15);
        return r;
    endfunction

    task automatic sample();
        accepted = 1'b0;
        if (rst) begin
            q.delete();
            fsum = 0;
        end else begin
            if (out_valid8 || out_valid4) begin
                vcount++;
                chk("valid8", out_valid8, 1);
                chk("valid4", out_valid4, 1);
                chk("result_expected", q.size() != 0, 1);
                if (q.size() != 0) begin
                    chk("count8", out_count8, q[0].c8);
                    chk("sat8", out_sat8, q[0].s8);
                    chk("count4", out_count4, q[0].c4);
                    chk("sat4", out_sat4, q[0].s4);
                    if (out_ready) void'(q.pop_front());
                end
            end
            if (in_valid && in_ready8) begin
                accepted = 1'b1;
                fsum += $countones(in_data);
                if (in_last) begin
                    q.push_back(frame_result(fsum));
                    fsum = 0;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        sample();
        @(posedge clk);
        #1;
        cyc++;
        if (rand_ready) out_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic send(input logic [6:0] d, input logic last);
        int n;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        n = 0;
        do begin
            step();
            n++;
        end while (!accepted && n < 50);
        if (!accepted) chk("send_timeout", 0, 1);
    endtask

    task automatic drain();
        int n;
        rand_ready = 1'b0;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        n = 0;
        while ((q.size() != 0 || out_valid8) && n < 40) begin
            step();
            n++;
        end
        chk("drain_queue", q.size(), 0);
        chk("drain_valid", out_valid8, 0);
    endtask

    initial begin
        int c0;

        // reset with random inputs
        rst = 1'b1;
        repeat (2) begin
            in_valid  = 1'($urandom_range(0, 1));
            in_data   = 7'($urandom);
            in_last   = 1'($urandom_range(0, 1));
            out_ready = 1'($urandom_range(0, 1));
            step();
        end
        rst = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        chk("rst_valid", out_valid8, 0);
        chk("rst_count", out_count8, 0);
        chk("rst_sat", out_sat8, 0);
        chk("rst_in_ready", in_ready8, 1);
        chk("rst_in_ready4", in_ready4, 1);

        // basic frame
        send(7'h7F, 1'b0);
        send(7'h01, 1'b0);
        send(7'h55, 1'b1);
        in_valid = 1'b0;
        step();
        chk("basic_valid", out_valid8, 1);
        chk("basic_count", out_count8, 12);
        chk("basic_sat", out_sat8, 0);
        step();
        chk("basic_once", out_valid8, 0);

        // saturation
        send(7'h7F, 1'b0);
        send(7'h7F, 1'b0);
        send(7'h7F, 1'b1);
        in_valid = 1'b0;
        step();
        chk("sat_count4", out_count4, 15);
        chk("sat_sat4", out_sat4, 1);
        chk("sat_count8", out_count8, 21);
        chk("sat_sat8", out_sat8, 0);
        send(7'h03, 1'b1);
        in_valid = 1'b0;
        step();
        chk("sat_next_count4", out_count4, 2);
        chk("sat_next_sat4", out_sat4, 0);
        drain();

        // backpressure
        out_ready = 1'b0;
        send(7'h07, 1'b1);
        send(7'h1F, 1'b1);
        chk("bp_in_ready8", in_ready8, 0);
        chk("bp_in_ready4", in_ready4, 0);
        in_valid = 1'b1;
        in_data  = 7'h01;
        in_last  = 1'b1;
        repeat (3) begin
            step();
            chk("bp_hold_count", out_count8, 3);
            chk("bp_hold_ready", in_ready8, 0);
        end
        out_ready = 1'b1;
        send(7'h01, 1'b1);
        drain();

        // reset mid-frame
        send(7'h7F, 1'b0);
        send(7'h7F, 1'b0);
        in_valid = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        send(7'h03, 1'b1);
        in_valid = 1'b0;
        step();
        chk("midrst_count8", out_count8, 2);
        chk("midrst_count4", out_count4, 2);
        drain();

        // back-to-back singles at full rate
        vcount = 0;
        c0 = cyc;
        for (int i = 0; i < 8; i++) send(7'((1 << i) - 1), 1'b1);
        chk("b2b_in_cycles", cyc - c0, 8);
        in_valid = 1'b0;
        step();
        step();
        chk("b2b_valid_cycles", vcount, 8);
        drain();

        // same singles with random out_ready
        rand_ready = 1'b1;
        for (int i = 0; i < 8; i++) send(7'((1 << i) - 1), 1'b1);
        drain();

        // random traffic
        rand_ready = 1'b1;
        for (int i = 0; i < 400; i++) begin
            in_valid = 1'($urandom_range(0, 3) != 0);
            in_data  = 7'($urandom);
            in_last  = 1'($urandom_range(0, 4) == 0);
            step();
        end
        in_valid = 1'b1;
        in_data  = 7'($urandom);
        send(in_data, 1'b1);
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
